// File: rtl/cpu_step_pkg.sv
// rtl/cpu_step_pkg.sv - shared types for the CPU run-control front end
// Contents:
//   cpu_mode_e   : run mode selected by the board switches
//   dbnc_state_e : step-button debounce FSM states
package cpu_step_pkg;

    typedef enum logic [1:0] {
        MODE_HALT = 2'b00,
        MODE_SLOW = 2'b01,
        MODE_FULL = 2'b10,
        MODE_STEP = 2'b11
    } cpu_mode_e;

    typedef enum logic [1:0] {
        DB_RELEASED     = 2'b00,
        DB_PRESS_WAIT   = 2'b01,
        DB_PRESSED      = 2'b10,
        DB_RELEASE_WAIT = 2'b11
    } dbnc_state_e;

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// rtl/cpu_step_ctrl_btn_debounce.sv - step-button synchroniser and debounce FSM
// Ports:
//   clk, rst       : system clock, synchronous active-high reset
//   i_step_btn_n   : raw active-low push-button, asynchronous and bouncy
//   o_btn_pressed  : debounced level, 1 while pressed (PRESSED / RELEASE_WAIT)
//   o_press_event  : one-cycle strobe on the PRESS_WAIT -> PRESSED transition
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_step_btn_n,
    output logic o_btn_pressed,
    output logic o_press_event
);
    import cpu_step_pkg::*;

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    dbnc_state_e   r_state;
    logic [CW-1:0] r_cnt;
    logic          r_pressed;
    logic          w_press;
    logic          w_done;

    assign w_press = ~r_sync[1];
    // The counter holds the number of stable samples already seen in a
    // WAIT state, so the sample that matches on CNT_LAST is the last one.
    assign w_done  = (r_cnt == CNT_LAST);

    // Combinational so the top can register cpu_ce on the same edge the
    // FSM enters PRESSED.
    assign o_press_event = (r_state == DB_PRESS_WAIT) && w_press && w_done;
    assign o_btn_pressed = r_pressed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= 2'b11;
            r_state   <= DB_RELEASED;
            r_cnt     <= '0;
            r_pressed <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_step_btn_n};
            case (r_state)
                DB_RELEASED: begin
                    r_cnt <= '0;
                    if (w_press) r_state <= DB_PRESS_WAIT;
                end
                DB_PRESS_WAIT: begin
                    if (!w_press) begin
                        r_state <= DB_RELEASED;
                        r_cnt   <= '0;
                    end else if (w_done) begin
                        r_state   <= DB_PRESSED;
                        r_cnt     <= '0;
                        r_pressed <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DB_PRESSED: begin
                    r_cnt <= '0;
                    if (!w_press) r_state <= DB_RELEASE_WAIT;
                end
                DB_RELEASE_WAIT: begin
                    if (w_press) begin
                        r_state <= DB_PRESSED;
                        r_cnt   <= '0;
                    end else if (w_done) begin
                        r_state   <= DB_RELEASED;
                        r_cnt     <= '0;
                        r_pressed <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= DB_RELEASED;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - run-control clock-enable generator for the RV32I core
// Ports:
//   clk, rst     : 50 MHz system clock, synchronous active-high reset
//   step_btn_n   : raw active-low step key (asynchronous, bouncy)
//   mode         : raw switches, 00 HALT / 01 SLOW / 10 FULL / 11 STEP
//   cpu_ce       : registered core clock-enable
//   heartbeat    : registered, toggles every TICK_DIV cycles
//   btn_pressed  : debounced step key level
//   cycle_count  : cpu_ce pulses since reset
// Build option: CPU_STEP_CYCLE_COUNT_EN builds the cycle counter; otherwise
// cycle_count is tied to 0.
module cpu_step_ctrl #(
    parameter int TICK_DIV        = 5_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_btn_n,
    input  logic [1:0]  mode,
    output logic        cpu_ce,
    output logic        heartbeat,
    output logic        btn_pressed,
    output logic [31:0] cycle_count
);
    import cpu_step_pkg::*;

    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    cpu_mode_e   r_mode_s1;
    cpu_mode_e   r_mode_s2;
    cpu_mode_e   r_mode_prev;
    logic [DW-1:0] r_div;
    logic        r_cpu_ce;
    logic        r_heartbeat;
    logic        w_tick;
    logic        w_press_event;
    logic        w_btn_pressed;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk           (clk),
        .rst           (rst),
        .i_step_btn_n  (step_btn_n),
        .o_btn_pressed (w_btn_pressed),
        .o_press_event (w_press_event)
    );

    assign w_tick      = (r_div == DIV_LAST);
    assign cpu_ce      = r_cpu_ce;
    assign heartbeat   = r_heartbeat;
    assign btn_pressed = w_btn_pressed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_s1   <= MODE_HALT;
            r_mode_s2   <= MODE_HALT;
            r_mode_prev <= MODE_HALT;
            r_div       <= '0;
            r_cpu_ce    <= 1'b0;
            r_heartbeat <= 1'b0;
        end else begin
            r_mode_s1   <= cpu_mode_e'(mode);
            r_mode_s2   <= r_mode_s1;
            r_mode_prev <= r_mode_s2;

            // Entering SLOW realigns the divider so the first slow pulse
            // lands a full period after the switch takes effect.
            if ((r_mode_s2 == MODE_SLOW) && (r_mode_prev != MODE_SLOW))
                r_div <= '0;
            else if (w_tick)
                r_div <= '0;
            else
                r_div <= r_div + 1'b1;

            if (w_tick) r_heartbeat <= ~r_heartbeat;

            case (r_mode_s2)
                MODE_HALT: r_cpu_ce <= 1'b0;
                MODE_SLOW: r_cpu_ce <= w_tick;
                MODE_FULL: r_cpu_ce <= 1'b1;
                MODE_STEP: r_cpu_ce <= w_press_event;
                default:   r_cpu_ce <= 1'b0;
            endcase
        end
    end

`ifdef CPU_STEP_CYCLE_COUNT_EN
    logic [31:0] r_cycle_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_cycle_count <= '0;
        else if (r_cpu_ce)
            r_cycle_count <= r_cycle_count + 32'd1;
    end

    assign cycle_count = r_cycle_count;
`else
    assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - self-checking bench for cpu_step_ctrl
module tb_cpu_step_ctrl;

    logic        clk;
    logic        rst;
    logic        step_btn_n;
    logic [1:0]  mode;
    logic        cpu_ce;
    logic        heartbeat;
    logic        btn_pressed;
    logic [31:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef CPU_STEP_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    cpu_step_ctrl #(
        .TICK_DIV        (4),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .step_btn_n  (step_btn_n),
        .mode        (mode),
        .cpu_ce      (cpu_ce),
        .heartbeat   (heartbeat),
        .btn_pressed (btn_pressed),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        step_btn_n = 1'b1;
        mode       = 2'b00;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        step_btn_n = 1'b1;
        mode       = 2'b10;
        repeat (3) step();
        n_checks++;
        if (cpu_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cpu_ce: got %0b expected 0", cpu_ce);
        end
        n_checks++;
        if (heartbeat !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_heartbeat: got %0b expected 0", heartbeat);
        end
        n_checks++;
        if (btn_pressed !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_btn_pressed: got %0b expected 0", btn_pressed);
        end
        n_checks++;
        if (cycle_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_cycle_count: got %0h expected 0", cycle_count);
        end
    endtask

    task automatic test_full();
        logic [31:0] exp_cnt;
        mode = 2'b10;
        rst  = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            step();
            n_checks++;
            if (cpu_ce !== (k >= 2)) begin
                n_fail++;
                $display("FAIL full_cpu_ce edge %0d: got %0b expected %0b", k, cpu_ce, (k >= 2));
            end
        end
        exp_cnt = CNT_EN ? 32'd10 : 32'd0;
        n_checks++;
        if (cycle_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL full_cycle_count: got %0d expected %0d", cycle_count, exp_cnt);
        end
    endtask

    task automatic test_slow();
        logic prev_hb;
        logic exp_ce;
        mode    = 2'b01;
        prev_hb = heartbeat;
        for (int k = 0; k <= 18; k++) begin
            step();
            if (k >= 3) begin
                exp_ce = (k == 6) || (k == 10) || (k == 14) || (k == 18);
                n_checks++;
                if (cpu_ce !== exp_ce) begin
                    n_fail++;
                    $display("FAIL slow_cpu_ce edge %0d: got %0b expected %0b", k, cpu_ce, exp_ce);
                end
                n_checks++;
                if ((heartbeat !== prev_hb) !== exp_ce) begin
                    n_fail++;
                    $display("FAIL slow_heartbeat edge %0d: toggled %0b expected %0b", k, (heartbeat !== prev_hb), exp_ce);
                end
            end
            prev_hb = heartbeat;
        end
    endtask

    task automatic test_step_bounce();
        logic [31:0] exp_cnt;
        do_reset();
        mode = 2'b11;
        repeat (3) step();
        step_btn_n = 1'b1; step();
        step_btn_n = 1'b0; step();
        step_btn_n = 1'b1; step();
        step_btn_n = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            step();
            n_checks++;
            if (cpu_ce !== (k == 5)) begin
                n_fail++;
                $display("FAIL step_cpu_ce edge %0d: got %0b expected %0b", k, cpu_ce, (k == 5));
            end
            if (k == 4 || k == 5) begin
                n_checks++;
                if (btn_pressed !== (k == 5)) begin
                    n_fail++;
                    $display("FAIL step_btn_pressed edge %0d: got %0b expected %0b", k, btn_pressed, (k == 5));
                end
            end
        end
        n_checks++;
        if (btn_pressed !== 1'b1) begin
            n_fail++;
            $display("FAIL step_btn_held: got %0b expected 1", btn_pressed);
        end
        exp_cnt = CNT_EN ? 32'd1 : 32'd0;
        n_checks++;
        if (cycle_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL step_cycle_count: got %0d expected %0d", cycle_count, exp_cnt);
        end
    endtask

    task automatic test_halt_press();
        do_reset();
        repeat (3) step();
        step_btn_n = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            step();
            n_checks++;
            if (cpu_ce !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_press_cpu_ce edge %0d: got %0b expected 0", k, cpu_ce);
            end
        end
        n_checks++;
        if (btn_pressed !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_btn_pressed: got %0b expected 1", btn_pressed);
        end
        // Switch into STEP with the key already held: must not pulse.
        mode = 2'b11;
        for (int k = 0; k < 8; k++) begin
            step();
            n_checks++;
            if (cpu_ce !== 1'b0) begin
                n_fail++;
                $display("FAIL held_into_step_cpu_ce edge %0d: got %0b expected 0", k, cpu_ce);
            end
        end
        mode       = 2'b00;
        step_btn_n = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            step();
            n_checks++;
            if (cpu_ce !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_release_cpu_ce edge %0d: got %0b expected 0", k, cpu_ce);
            end
        end
        n_checks++;
        if (btn_pressed !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_btn_released: got %0b expected 0", btn_pressed);
        end
        n_checks++;
        if (cycle_count !== 32'd0) begin
            n_fail++;
            $display("FAIL halt_cycle_count: got %0d expected 0", cycle_count);
        end
    endtask

`ifdef CPU_STEP_CYCLE_COUNT_EN
    task automatic test_count_wrap();
        do_reset();
        force dut.r_cycle_count = 32'hFFFF_FFFF;
        step();
        release dut.r_cycle_count;
        step();
        n_checks++;
        if (cycle_count !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL wrap_preload: got %0h expected ffffffff", cycle_count);
        end
        mode = 2'b10;
        for (int k = 0; k <= 3; k++) begin
            step();
            if (k == 2) begin
                n_checks++;
                if (cycle_count !== 32'hFFFF_FFFF) begin
                    n_fail++;
                    $display("FAIL wrap_before: got %0h expected ffffffff", cycle_count);
                end
            end
        end
        n_checks++;
        if (cycle_count !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap_to_zero: got %0h expected 0", cycle_count);
        end
    endtask
`endif

    task automatic test_reset_mid_press();
        do_reset();
        mode = 2'b11;
        repeat (3) step();
        step_btn_n = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        n_checks++;
        if (cpu_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_cpu_ce: got %0b expected 0", cpu_ce);
        end
        n_checks++;
        if (heartbeat !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_heartbeat: got %0b expected 0", heartbeat);
        end
        n_checks++;
        if (btn_pressed !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_btn_pressed: got %0b expected 0", btn_pressed);
        end
        n_checks++;
        if (cycle_count !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_cycle_count: got %0h expected 0", cycle_count);
        end
        rst        = 1'b0;
        step_btn_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            n_checks++;
            if (cpu_ce !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_no_pulse edge %0d: got %0b expected 0", k, cpu_ce);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        step_btn_n = 1'b1;
        mode       = 2'b00;
        test_reset();
        test_full();
        test_slow();
        test_step_bounce();
        test_halt_press();
`ifdef CPU_STEP_CYCLE_COUNT_EN
        test_count_wrap();
`endif
        test_reset_mid_press();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
